conv2d_stream_engine: RTL and testbench
=======================================

// Module: conv2d_stream_engine
// PURPOSE
//  Streaming KxK 2-D convolution over a raster-order pixel stream, fully parametrised in kernel size, image size and widths.
//  K row units of K taps each; partial sums flow row to row through enable-gated delay lines of IMG_W-K beats.
//  Adds a valid/stall input, runtime weight load, a bias, border masking, end-of-frame flag and output saturation.
//  Sits between the pixel source and the activation/pool stage of the CNN datapath.
// PARAMETERS
//  K       5   kernel height and width (2..7)
//  IMG_W   32  image width in pixels (> K)
//  IMG_H   32  image height in pixels (>= K)
//  I_X     8   signed pixel width
//  I_W     8   signed weight width
//  I_BIAS  16  signed bias width
//  O_SAT   16  signed saturated output width
// PORTS
//  i_clk     in   1                  clock, rising edge
//  i_rst_n   in   1                  synchronous active-low reset
//  i_clear   in   1                  sync flush: counters + pipeline to 0, weights kept
//  i_valid   in   1                  pixel beat present; pipeline advances only when high
//  i_x       in   I_X                signed pixel, raster order
//  i_w_we    in   1                  weight write strobe
//  i_w_addr  in   clog2(K*K)         weight index = row*K + col
//  i_w       in   I_W                signed weight data
//  i_bias    in   I_BIAS             signed bias, static during a frame
//  o_valid   out  1                  o_psum holds a valid window result
//  o_psum    out  O_SAT              saturated convolution result
//  o_last    out  1                  high with the final o_valid of a frame
// BEHAVIOUR
//  - Reset (i_rst_n=0 at edge): o_valid=0, o_psum=0, o_last=0, col/row counters=0, all pipeline regs=0, all weights=0.
//  - Accepted beat = cycle with i_valid=1 and i_clear=0. Only accepted beats advance tap regs, delay lines, counters.
//  - Counters: col 0..IMG_W-1; wraps to 0 and row increments; after (IMG_H-1, IMG_W-1) both wrap to 0.
//  - For accepted pixel (r,c) with r>=K-1 and c>=K-1: next cycle o_valid=1 and
//    o_psum = sat(i_bias + sum_{i,j<K} w[i*K+j] * x[r-K+1+i][c-K+1+j]); any other cycle o_valid=0.
//  - Windows straddling a row wrap (c<K-1) or the first K-1 rows are never flagged valid.
//  - o_psum holds its last value while o_valid=0; only o_valid qualifies it.
//  - Latency: one cycle from accepting the window's last pixel; stalls (i_valid=0) add no bubbles or corruption.
//  - o_last=1 only in the cycle o_valid reports pixel (IMG_H-1, IMG_W-1).
//  - Arithmetic: products I_X+I_W bits; accumulate at ACC_W = I_X+I_W+clog2(K*K)+1 plus the bias extension; no internal wrap.
//  - Saturate only at the output: above 2^(O_SAT-1)-1 -> 2^(O_SAT-1)-1; below -2^(O_SAT-1) -> -2^(O_SAT-1).
//  - Weight write updates w[i_w_addr] at the edge. An accepted pixel in the same cycle uses the old weight.
//  - Weight writes mid-frame are legal; windows in flight then mix old and new weights (undefined result, no hang).
//  - i_clear=1: same as reset except weights retained; a simultaneous i_valid beat is dropped; o_valid=0 next cycle.
//  - i_w_we with i_clear: the write still takes effect.
//  - Reset or clear mid-frame: the next accepted pixel is (0,0); no outputs from the aborted frame appear.
// STRUCTURE
//  - conv_pkg: ACC_W and WADDR_W constants, sat() function, clog2 helper.
//  - Sub-module conv_row_unit (instantiated K times): K-tap transposed MAC row with enable, taking psum in and psum out.
//    It contains an enable-gated delay line of IMG_W-K stages. The last instance has no delay line.
//  - Top level: weight register file, bias injection into row unit 0, col/row counters, valid mask, output sat register.
// TESTING
//  - Overrides K=3, IMG_W=6, IMG_H=4. All w=1, bias=0, x=1 every beat:
//    exactly 8 o_valid per frame, each o_psum=9; o_last on the 8th only.
//  - Same overrides, only w[4]=1 (centre), x=r*16+c: result for (r,c) = (r-1)*16+(c-1), e.g. (3,5) -> 36.
//  - Defaults, all w=127, x=127, bias=0: o_psum=32767. x=-128: o_psum=-32768.
//  - Test 2 again with random i_valid=0 gaps (~30%): output sequence identical to the gapless run.
//  - i_clear asserted after 10 beats, then a full frame: 8 outputs, no extras, weights unchanged; bias=5 -> each o_psum=14.
//  - i_rst_n low mid-frame: outputs 0 next cycle, weights 0; reload weights, run a frame -> matches test 1.

Source files
------------

// File: rtl/conv_pkg.sv
// Shared helpers for the streaming convolution engine: width calculators
// and the output saturation function.
package conv_pkg;

    // Ceiling log2 of a positive integer (returns 0 for 1).
    function automatic int clog2(input int value);
        int result;
        int span;
        result = 0;
        span   = 1;
        while (span < value) begin
            span   = span * 2;
            result = result + 1;
        end
        return result;
    endfunction

    // Accumulator width: full product width plus growth for K*K terms, plus
    // one guard bit above whichever is wider of that sum and the bias.
    function automatic int acc_width(input int k, input int x_w, input int w_w, input int bias_w);
        int base;
        base = x_w + w_w + clog2(k * k) + 1;
        return ((base > bias_w) ? base : bias_w) + 1;
    endfunction

    // Weight address width for a KxK kernel.
    function automatic int waddr_width(input int k);
        return clog2(k * k);
    endfunction

    // Clamp a wide signed value into the signed range of out_w bits.
    function automatic logic signed [63:0] sat(input logic signed [63:0] value, input int out_w);
        logic signed [63:0] max_v;
        logic signed [63:0] min_v;
        max_v = (64'sd1 <<< (out_w - 1)) - 64'sd1;
        min_v = -(64'sd1 <<< (out_w - 1));
        if (value > max_v) begin
            return max_v;
        end
        if (value < min_v) begin
            return min_v;
        end
        return value;
    endfunction

endpackage

// File: rtl/conv_row_unit.sv
// One kernel row of the convolution: K-tap transposed MAC chain fed by the
// broadcast pixel, followed (except in the last row) by an enable-gated
// delay line that lines the row's partial sum up with the next image row.
module conv_row_unit
    import conv_pkg::*;
#(
    parameter int K     = 5,
    parameter int DELAY = 27,
    parameter int I_X   = 8,
    parameter int I_W   = 8,
    parameter int ACC_W = 23,
    parameter bit LAST  = 1'b0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    clear,
    input  logic                    en,
    input  logic [I_X-1:0]          x,
    input  logic [K*I_W-1:0]        w,
    input  logic signed [ACC_W-1:0] psum_in,
    output logic signed [ACC_W-1:0] psum_out
);

    localparam int PW = I_X + I_W;

    logic signed [PW-1:0]    x_ext;
    logic signed [PW-1:0]    w_ext [K];
    logic signed [PW-1:0]    mul   [K];
    logic signed [ACC_W-1:0] prod  [K];
    logic signed [ACC_W-1:0] tap_q [K-1];
    logic signed [ACC_W-1:0] tap_next;

    // Per-tap products, sign-extended to full product width then accumulator width.
    always_comb begin
        x_ext = PW'($signed(x));
        w_ext = '{default: '0};
        mul   = '{default: '0};
        prod  = '{default: '0};
        for (int j = 0; j < K; j++) begin
            w_ext[j] = PW'($signed(w[j*I_W +: I_W]));
            mul[j]   = x_ext * w_ext[j];
            prod[j]  = ACC_W'(mul[j]);
        end
    end

    // Transposed tap chain: tap j holds psum_in plus products of the last j+1 pixels.
    always_ff @(posedge clk) begin
        if (!rst_n || clear) begin
            for (int j = 0; j < K - 1; j++) begin
                tap_q[j] <= '0;
            end
        end else if (en) begin
            tap_q[0] <= psum_in + prod[0];
            for (int j = 1; j < K - 1; j++) begin
                tap_q[j] <= tap_q[j-1] + prod[j];
            end
        end
    end

    // Complete row window sum for the pixel being accepted this cycle.
    assign tap_next = tap_q[K-2] + prod[K-1];

    if (LAST) begin : g_last
        assign psum_out = tap_next;
    end else begin : g_delay
        logic signed [ACC_W-1:0] last_q;
        logic signed [ACC_W-1:0] dly_q [DELAY];

        // Final tap register plus DELAY-stage line; together they span IMG_W-K+1 beats.
        always_ff @(posedge clk) begin
            if (!rst_n || clear) begin
                last_q <= '0;
                for (int i = 0; i < DELAY; i++) begin
                    dly_q[i] <= '0;
                end
            end else if (en) begin
                last_q   <= tap_next;
                dly_q[0] <= last_q;
                for (int i = 1; i < DELAY; i++) begin
                    dly_q[i] <= dly_q[i-1];
                end
            end
        end

        assign psum_out = dly_q[DELAY-1];
    end

endmodule

// File: rtl/conv2d_stream_engine.sv
// Streaming KxK 2-D convolution over a raster-order pixel stream. Holds the
// weight file, injects the bias into row 0, tracks the pixel position,
// masks border windows and saturates the registered result.
//
// Stream protocol: there is no back-pressure. A beat is taken on any cycle
// with i_valid=1 and i_clear=0; idle cycles freeze the whole pipeline.
// o_valid is a one-cycle qualifier for o_psum and the sink must take it.
module conv2d_stream_engine
    import conv_pkg::*;
#(
    parameter int K      = 5,
    parameter int IMG_W  = 32,
    parameter int IMG_H  = 32,
    parameter int I_X    = 8,
    parameter int I_W    = 8,
    parameter int I_BIAS = 16,
    parameter int O_SAT  = 16
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic                      i_clear,
    input  logic                      i_valid,
    input  logic [I_X-1:0]            i_x,
    input  logic                      i_w_we,
    input  logic [waddr_width(K)-1:0] i_w_addr,
    input  logic [I_W-1:0]            i_w,
    input  logic [I_BIAS-1:0]         i_bias,
    output logic                      o_valid,
    output logic [O_SAT-1:0]          o_psum,
    output logic                      o_last
);

    localparam int ACC_W = acc_width(K, I_X, I_W, I_BIAS);
    localparam int COL_W = clog2(IMG_W);
    localparam int ROW_W = clog2(IMG_H);
    localparam logic [COL_W-1:0] COL_FIRST = COL_W'(K - 1);
    localparam logic [COL_W-1:0] COL_LAST  = COL_W'(IMG_W - 1);
    localparam logic [ROW_W-1:0] ROW_FIRST = ROW_W'(K - 1);
    localparam logic [ROW_W-1:0] ROW_LAST  = ROW_W'(IMG_H - 1);

    logic [I_W-1:0]          w_q   [K*K];
    logic [K*I_W-1:0]        row_w [K];
    logic signed [ACC_W-1:0] chain [K+1];
    logic signed [O_SAT-1:0] sat_res;
    logic [COL_W-1:0]        col_q;
    logic [ROW_W-1:0]        row_q;
    logic                    accept;
    logic                    in_window;
    logic                    frame_end;

    assign accept    = i_valid && !i_clear;
    assign in_window = (row_q >= ROW_FIRST) && (col_q >= COL_FIRST);
    assign frame_end = (row_q == ROW_LAST) && (col_q == COL_LAST);
    assign chain[0]  = ACC_W'($signed(i_bias));

    // Weight register file; clear leaves it alone, reset zeroes it.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < K * K; i++) begin
                w_q[i] <= '0;
            end
        end else if (i_w_we && (int'(i_w_addr) < K * K)) begin
            w_q[i_w_addr] <= i_w;
        end
    end

    // Pack each kernel row's weights for its row unit (column 0 in the low slice).
    always_comb begin
        row_w = '{default: '0};
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                row_w[i][j*I_W +: I_W] = w_q[i*K+j];
            end
        end
    end

    for (genvar i = 0; i < K; i++) begin : g_row
        conv_row_unit #(
            .K     (K),
            .DELAY (IMG_W - K),
            .I_X   (I_X),
            .I_W   (I_W),
            .ACC_W (ACC_W),
            .LAST  (i == K - 1)
        ) u_row (
            .clk      (i_clk),
            .rst_n    (i_rst_n),
            .clear    (i_clear),
            .en       (accept),
            .x        (i_x),
            .w        (row_w[i]),
            .psum_in  (chain[i]),
            .psum_out (chain[i+1])
        );
    end

    // Saturate the full window sum down to the output width.
    always_comb begin
        sat_res = O_SAT'(sat(64'(chain[K]), O_SAT));
    end

    // Position counters, border mask and registered output.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n || i_clear) begin
            col_q   <= '0;
            row_q   <= '0;
            o_valid <= 1'b0;
            o_psum  <= '0;
            o_last  <= 1'b0;
        end else begin
            o_valid <= accept && in_window;
            o_last  <= accept && in_window && frame_end;
            if (accept && in_window) begin
                o_psum <= sat_res;
            end
            if (accept) begin
                if (col_q == COL_LAST) begin
                    col_q <= '0;
                    row_q <= (row_q == ROW_LAST) ? '0 : row_q + ROW_W'(1);
                end else begin
                    col_q <= col_q + COL_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_conv2d_stream_engine.sv
// Self-checking bench for conv2d_stream_engine with a 3x3 kernel on a 6x4 image.
module tb_conv2d_stream_engine;

    localparam int K      = 3;
    localparam int IMG_W  = 6;
    localparam int IMG_H  = 4;
    localparam int I_X    = 8;
    localparam int I_W    = 8;
    localparam int I_BIAS = 16;
    localparam int O_SAT  = 16;
    localparam int SAT_MAX = 32767;
    localparam int SAT_MIN = -32768;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              clear = 1'b0;
    logic              valid = 1'b0;
    logic [I_X-1:0]    x = '0;
    logic              w_we = 1'b0;
    logic [3:0]        w_addr = '0;
    logic [I_W-1:0]    w_data = '0;
    logic [I_BIAS-1:0] bias = '0;
    logic              o_valid;
    logic [O_SAT-1:0]  o_psum;
    logic              o_last;

    // clock / reset
    always #5 clk = ~clk;

    conv2d_stream_engine #(
        .K(K), .IMG_W(IMG_W), .IMG_H(IMG_H),
        .I_X(I_X), .I_W(I_W), .I_BIAS(I_BIAS), .O_SAT(O_SAT)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_clear  (clear),
        .i_valid  (valid),
        .i_x      (x),
        .i_w_we   (w_we),
        .i_w_addr (w_addr),
        .i_w      (w_data),
        .i_bias   (bias),
        .o_valid  (o_valid),
        .o_psum   (o_psum),
        .o_last   (o_last)
    );

    // reference model state: weights, bias, current frame image, position
    int wm [K*K];
    int bm = 0;
    int img [IMG_H][IMG_W];
    int mr = 0;
    int mc = 0;

    logic [O_SAT:0]   exp_q[$];
    int               n_total = 0;
    int               n_bad = 0;
    int               n_out = 0;
    logic             mon_en = 1'b0;
    logic [O_SAT-1:0] hold_ref = '0;

    function automatic int s8(input int u);
        return (u > 127) ? u - 256 : u;
    endfunction

    function automatic int clamp(input int v);
        if (v > SAT_MAX) return SAT_MAX;
        if (v < SAT_MIN) return SAT_MIN;
        return v;
    endfunction

    // Model: record pixel, and if a full window ends here, push its result.
    task automatic model_accept(input int xv);
        int   sum;
        logic lb;
        img[mr][mc] = xv;
        if (mr >= K - 1 && mc >= K - 1) begin
            sum = bm;
            for (int i = 0; i < K; i++) begin
                for (int j = 0; j < K; j++) begin
                    sum += wm[i*K+j] * img[mr-K+1+i][mc-K+1+j];
                end
            end
            lb = (mr == IMG_H - 1 && mc == IMG_W - 1) ? 1'b1 : 1'b0;
            exp_q.push_back({lb, 16'(clamp(sum))});
        end
        mc++;
        if (mc == IMG_W) begin
            mc = 0;
            mr++;
            if (mr == IMG_H) mr = 0;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int got, input int req);
        n_total++;
        if (got != req) begin
            n_bad++;
            $display("FAIL %s: got %0d, required %0d", name, got, req);
        end
    endtask

    // driver tasks
    task automatic pixel(input int xv, input int gap_pct);
        for (int g = 0; g < 5; g++) begin
            if ($urandom_range(0, 99) >= gap_pct) break;
            valid = 1'b0;
            x = 8'($urandom);
            tick();
        end
        valid = 1'b1;
        x = 8'(xv);
        model_accept(xv);
        tick();
        valid = 1'b0;
    endtask

    task automatic pixel_write(input int xv, input int addr, input int val);
        valid = 1'b1;
        x = 8'(xv);
        w_we = 1'b1;
        w_addr = 4'(addr);
        w_data = 8'(val);
        model_accept(xv);
        wm[addr] = val;
        tick();
        valid = 1'b0;
        w_we = 1'b0;
    endtask

    task automatic write_w(input int addr, input int val);
        w_we = 1'b1;
        w_addr = 4'(addr);
        w_data = 8'(val);
        tick();
        w_we = 1'b0;
        wm[addr] = val;
    endtask

    task automatic set_all_w(input int val);
        for (int i = 0; i < K * K; i++) write_w(i, val);
    endtask

    task automatic set_bias(input int v);
        bias = 16'(v);
        bm = v;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        valid = 1'b1;
        x = 8'($urandom);
        tick();
        rst_n = 1'b1;
        valid = 1'b0;
        for (int i = 0; i < K * K; i++) wm[i] = 0;
        mr = 0;
        mc = 0;
        hold_ref = '0;
        check("reset_valid", int'(o_valid), 0);
        check("reset_psum", int'(o_psum), 0);
        check("reset_last", int'(o_last), 0);
    endtask

    task automatic do_clear(input bit we, input int addr, input int val);
        clear = 1'b1;
        valid = 1'b1;
        x = 8'($urandom);
        w_we = we;
        w_addr = 4'(addr);
        w_data = 8'(val);
        tick();
        clear = 1'b0;
        valid = 1'b0;
        w_we = 1'b0;
        if (we) wm[addr] = val;
        mr = 0;
        mc = 0;
        hold_ref = '0;
        check("clear_valid", int'(o_valid), 0);
        check("clear_psum", int'(o_psum), 0);
    endtask

    task automatic frame_const(input int xv, input int gap_pct);
        for (int p = 0; p < IMG_W * IMG_H; p++) pixel(xv, gap_pct);
    endtask

    task automatic frame_ramp(input int gap_pct);
        for (int r = 0; r < IMG_H; r++)
            for (int c = 0; c < IMG_W; c++)
                pixel(r * 16 + c, gap_pct);
    endtask

    task automatic frame_rand(input int gap_pct);
        for (int p = 0; p < IMG_W * IMG_H; p++) pixel(s8($urandom_range(0, 255)), gap_pct);
    endtask

    task automatic drain(input string name);
        repeat (4) tick();
        check(name, exp_q.size(), 0);
    endtask

    // scoreboard monitor: pop and compare on every o_valid, check hold otherwise
    always @(negedge clk) begin
        logic [O_SAT:0] e;
        if (mon_en) begin
            if (o_valid === 1'b1) begin
                n_out++;
                n_total++;
                if (exp_q.size() == 0) begin
                    n_bad++;
                    $display("FAIL unexpected_output: got psum=%0d last=%0b, required no output",
                             $signed(o_psum), o_last);
                end else begin
                    e = exp_q.pop_front();
                    if ({o_last, o_psum} !== e) begin
                        n_bad++;
                        $display("FAIL psum_last: got psum=%0d last=%0b, required psum=%0d last=%0b",
                                 $signed(o_psum), o_last, $signed(e[O_SAT-1:0]), e[O_SAT]);
                    end
                end
                hold_ref = o_psum;
            end else begin
                n_total++;
                if (o_valid !== 1'b0 || o_last !== 1'b0 || o_psum !== hold_ref) begin
                    n_bad++;
                    $display("FAIL idle_hold: got valid=%0b last=%0b psum=%0d, required valid=0 last=0 psum=%0d",
                             o_valid, o_last, $signed(o_psum), $signed(hold_ref));
                end
            end
        end
    end

    int o0;

    initial begin
        do_reset();
        mon_en = 1'b1;

        // all-ones: 8 outputs of 9, last flagged on the 8th
        set_all_w(1);
        set_bias(0);
        o0 = n_out;
        frame_const(1, 0);
        drain("t1_drain");
        check("t1_count", n_out - o0, 8);

        // centre tap only on a ramp, gapless then with gaps
        set_all_w(0);
        write_w(4, 1);
        o0 = n_out;
        frame_ramp(0);
        drain("t2_drain");
        check("t2_count", n_out - o0, 8);
        o0 = n_out;
        frame_ramp(30);
        drain("t2_gap_drain");
        check("t2_gap_count", n_out - o0, 8);

        // saturation at both rails
        set_all_w(127);
        frame_const(127, 0);
        frame_const(-128, 10);
        drain("sat_drain");

        // weight write coinciding with the frame's last pixel uses the old weight
        set_all_w(1);
        for (int p = 0; p < IMG_W * IMG_H - 1; p++) pixel(1, 0);
        pixel_write(1, 8, 5);
        frame_const(1, 0);
        drain("wr_same_drain");

        // clear after 10 beats, then a frame with bias 5
        set_all_w(1);
        for (int p = 0; p < 10; p++) pixel(1, 0);
        do_clear(1'b0, 0, 0);
        set_bias(5);
        o0 = n_out;
        frame_const(1, 0);
        drain("clear_drain");
        check("clear_count", n_out - o0, 8);

        // clear with windows in flight plus a write during the clear
        for (int p = 0; p < 16; p++) pixel(1, 0);
        do_clear(1'b1, 4, 3);
        o0 = n_out;
        frame_const(1, 20);
        drain("clear_we_drain");
        check("clear_we_count", n_out - o0, 8);

        // reset mid-frame: weights zero, then reload
        for (int p = 0; p < 17; p++) pixel(p, 0);
        do_reset();
        frame_const(1, 0);
        drain("rst_zero_drain");
        set_all_w(1);
        set_bias(0);
        o0 = n_out;
        frame_const(1, 0);
        drain("rst_reload_drain");
        check("rst_reload_count", n_out - o0, 8);

        // random weights, bias, pixels and gaps
        for (int f = 0; f < 3; f++) begin
            for (int i = 0; i < K * K; i++) write_w(i, s8($urandom_range(0, 255)));
            set_bias(int'($urandom_range(0, 4000)) - 2000);
            frame_rand(30);
        end
        drain("rand_drain");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
